// File: rtl/sel_scan_pkg.sv
// sel_scan_pkg: shared types, select constants and source-advance helper for sel_scan
package sel_scan_pkg;

  typedef logic [1:0] sel_t;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

  localparam sel_t SEL_D0 = 2'd0;
  localparam sel_t SEL_D1 = 2'd1;
  localparam sel_t SEL_D2 = 2'd2;

  // Step one source forward in the 0->1->2->0 ring; never produces 2'b11.
  function automatic sel_t inc3(sel_t v);
    return (v == SEL_D2) ? SEL_D0 : sel_t'(v + 2'd1);
  endfunction

  // First enabled source in ring order. With incl=1 the search starts at cur
  // itself; with incl=0 it starts after cur and wraps back to cur last, so a
  // lone enabled source is picked again. Returns cur when nothing is enabled.
  function automatic sel_t next_en(sel_t cur, logic [2:0] m, logic incl);
    sel_t c0, c1, c2, r;
    c0 = incl ? cur : inc3(cur);
    c1 = inc3(c0);
    c2 = inc3(c1);
    r  = m[c2] ? c2 : cur;
    r  = m[c1] ? c1 : r;
    r  = m[c0] ? c0 : r;
    return r;
  endfunction

endpackage

// File: rtl/sel_scan_dwell_cnt.sv
// dwell_cnt: settle-time down counter, loads DWELL-1 and flags zero
module dwell_cnt #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [CW-1:0] cnt_q;

  // Load wins over decrement; decrement saturates at zero.
  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (load)
      cnt_q <= CW'(DWELL - 1);
    else if (dec && cnt_q != '0)
      cnt_q <= cnt_q - 1'b1;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/sel_scan.sv
// sel_scan: scans a 3:1 mux select, waits DWELL cycles per source, captures y with valid/ready
// Optional per-source mask port enabled by defining SEL_SCAN_MASK_EN.
module sel_scan
  import sel_scan_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
`ifdef SEL_SCAN_MASK_EN
  input  logic [2:0]       mask,
`endif
  input  logic [WIDTH-1:0] y,
  output logic [1:0]       s,
  output logic [WIDTH-1:0] q,
  output logic [1:0]       q_sel,
  output logic             q_valid,
  input  logic             q_ready
);

  state_t           state_q;
  sel_t             s_q;
  logic [WIDTH-1:0] q_q;
  sel_t             q_sel_q;
  logic             q_valid_q;
  logic [2:0]       m;
  logic             any_en;
  logic             hs;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero;

`ifdef SEL_SCAN_MASK_EN
  assign m = mask;
`else
  assign m = 3'b111;
`endif

  assign any_en   = |m;
  assign hs       = q_valid_q && q_ready;
  // A new dwell starts whenever a SETTLE is entered from IDLE or from a handshake.
  assign cnt_load = en && any_en && ((state_q == IDLE) || (state_q == HOLD && hs));
  assign cnt_dec  = (state_q == SETTLE);

  dwell_cnt #(.DWELL(DWELL)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .zero  (cnt_zero)
  );

  // Scan FSM: select sequencing, sample capture and output handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      s_q       <= SEL_D0;
      q_q       <= '0;
      q_sel_q   <= SEL_D0;
      q_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en && any_en) begin
            state_q <= SETTLE;
            s_q     <= next_en(s_q, m, 1'b1);
          end
        end
        SETTLE: begin
          if (!en) begin
            state_q <= IDLE;
          end else if (cnt_zero) begin
            q_q       <= y;
            q_sel_q   <= s_q;
            q_valid_q <= 1'b1;
            state_q   <= HOLD;
          end
        end
        HOLD: begin
          if (hs) begin
            q_valid_q <= 1'b0;
            if (any_en)
              s_q <= next_en(s_q, m, 1'b0);
            state_q <= (en && any_en) ? SETTLE : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s       = s_q;
  assign q       = q_q;
  assign q_sel   = q_sel_q;
  assign q_valid = q_valid_q;

endmodule

// File: tb/tb_sel_scan.sv
// tb_sel_scan: directed self-checking bench for sel_scan (mask tests only when SEL_SCAN_MASK_EN is defined)
module tb_sel_scan;
  import sel_scan_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] mask;
  logic [7:0] y;
  logic [1:0] s;
  logic [7:0] q;
  logic [1:0] q_sel;
  logic       q_valid;
  logic       q_ready;

  int checks = 0;
  int errors = 0;

  logic [7:0] dv [3] = '{8'h11, 8'h22, 8'h33};

  // Downstream 3:1 mux model
  assign y = (s == 2'd0) ? 8'h11 : (s == 2'd1) ? 8'h22 : (s == 2'd2) ? 8'h33 : 8'hxx;

  sel_scan #(.WIDTH(8), .DWELL(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
`ifdef SEL_SCAN_MASK_EN
    .mask    (mask),
`endif
    .y       (y),
    .s       (s),
    .q       (q),
    .q_sel   (q_sel),
    .q_valid (q_valid),
    .q_ready (q_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    en      = 1'b0;
    q_ready = 1'b0;
    mask    = 3'b111;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    en      = 1'b1;
    q_ready = 1'b1;
    mask    = 3'b111;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (s !== 2'd0) begin errors++; $display("FAIL reset_s cyc=%0d got %0h exp 0", i, s); end
      checks++;
      if (q !== 8'h00) begin errors++; $display("FAIL reset_q cyc=%0d got %0h exp 0", i, q); end
      checks++;
      if (q_sel !== 2'd0) begin errors++; $display("FAIL reset_qsel cyc=%0d got %0h exp 0", i, q_sel); end
      checks++;
      if (q_valid !== 1'b0) begin errors++; $display("FAIL reset_qvalid cyc=%0d got %0b exp 0", i, q_valid); end
    end
  endtask

  task automatic test_scan();
    logic       ev;
    logic [1:0] es;
    int         n;
    do_reset();
    en      = 1'b1;
    q_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      n  = c / 5;
      ev = (c % 5 == 4);
      es = 2'(n % 3);
      checks++;
      if (q_valid !== ev) begin errors++; $display("FAIL scan_qvalid cyc=%0d got %0b exp %0b", c, q_valid, ev); end
      checks++;
      if (s !== es) begin errors++; $display("FAIL scan_s cyc=%0d got %0h exp %0h", c, s, es); end
      if (ev) begin
        checks++;
        if (q !== dv[n % 3]) begin errors++; $display("FAIL scan_q cyc=%0d got %0h exp %0h", c, q, dv[n % 3]); end
        checks++;
        if (q_sel !== es) begin errors++; $display("FAIL scan_qsel cyc=%0d got %0h exp %0h", c, q_sel, es); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic       ev;
    logic [1:0] es;
    do_reset();
    en      = 1'b1;
    q_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      ev = (c >= 4 && c <= 14) || c == 19;
      es = (c >= 15) ? 2'd1 : 2'd0;
      checks++;
      if (q_valid !== ev) begin errors++; $display("FAIL bp_qvalid cyc=%0d got %0b exp %0b", c, q_valid, ev); end
      checks++;
      if (s !== es) begin errors++; $display("FAIL bp_s cyc=%0d got %0h exp %0h", c, s, es); end
      if (ev) begin
        checks++;
        if (q !== ((c == 19) ? 8'h22 : 8'h11)) begin errors++; $display("FAIL bp_q cyc=%0d got %0h", c, q); end
        checks++;
        if (q_sel !== es) begin errors++; $display("FAIL bp_qsel cyc=%0d got %0h exp %0h", c, q_sel, es); end
      end
      if (c == 14) q_ready = 1'b1;
    end
  endtask

  task automatic test_en_drop();
    do_reset();
    en      = 1'b1;
    q_ready = 1'b1;
    for (int c = 0; c < 7; c++) step();
    en = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      checks++;
      if (q_valid !== 1'b0) begin errors++; $display("FAIL endrop_qvalid cyc=%0d got %0b exp 0", c, q_valid); end
      checks++;
      if (s !== 2'd1) begin errors++; $display("FAIL endrop_s cyc=%0d got %0h exp 1", c, s); end
      checks++;
      if (q !== 8'h11 || q_sel !== 2'd0) begin errors++; $display("FAIL endrop_q cyc=%0d got %0h/%0h exp 11/0", c, q, q_sel); end
    end
    en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (q_valid !== (k == 4)) begin errors++; $display("FAIL enresume_qvalid k=%0d got %0b exp %0b", k, q_valid, k == 4); end
    end
    checks++;
    if (q !== 8'h22 || q_sel !== 2'd1) begin errors++; $display("FAIL enresume_q got %0h/%0h exp 22/1", q, q_sel); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    en      = 1'b1;
    q_ready = 1'b1;
    for (int c = 0; c < 7; c++) step();
    rst_n = 1'b0;
    step();
    checks++;
    if (s !== 2'd0 || q !== 8'h00 || q_sel !== 2'd0 || q_valid !== 1'b0) begin
      errors++; $display("FAIL midsettle_rst got s=%0h q=%0h qsel=%0h v=%0b exp all 0", s, q, q_sel, q_valid);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (q_valid !== (k == 4)) begin errors++; $display("FAIL postrst_qvalid k=%0d got %0b exp %0b", k, q_valid, k == 4); end
      checks++;
      if (s !== 2'd0) begin errors++; $display("FAIL postrst_s k=%0d got %0h exp 0", k, s); end
    end
    checks++;
    if (q !== 8'h11) begin errors++; $display("FAIL postrst_q got %0h exp 11", q); end
    q_ready = 1'b0;
    for (int c = 0; c < 6; c++) step();
    rst_n = 1'b0;
    step();
    checks++;
    if (s !== 2'd0 || q !== 8'h00 || q_sel !== 2'd0 || q_valid !== 1'b0) begin
      errors++; $display("FAIL midhold_rst got s=%0h q=%0h qsel=%0h v=%0b exp all 0", s, q, q_sel, q_valid);
    end
    rst_n = 1'b1;
  endtask

`ifdef SEL_SCAN_MASK_EN
  task automatic test_mask();
    logic       ev;
    logic [1:0] es;
    int         n;
    do_reset();
    mask    = 3'b101;
    en      = 1'b1;
    q_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      n  = c / 5;
      ev = (c % 5 == 4);
      es = (n % 2 == 1) ? 2'd2 : 2'd0;
      checks++;
      if (q_valid !== ev) begin errors++; $display("FAIL mask101_qvalid cyc=%0d got %0b exp %0b", c, q_valid, ev); end
      if (ev) begin
        checks++;
        if (q_sel !== es) begin errors++; $display("FAIL mask101_qsel cyc=%0d got %0h exp %0h", c, q_sel, es); end
        checks++;
        if (q !== dv[es]) begin errors++; $display("FAIL mask101_q cyc=%0d got %0h exp %0h", c, q, dv[es]); end
      end
    end
    do_reset();
    mask = 3'b000;
    en   = 1'b1;
    q_ready = 1'b1;
    for (int c = 0; c < 50; c++) begin
      step();
      checks++;
      if (q_valid !== 1'b0) begin errors++; $display("FAIL mask000_qvalid cyc=%0d got %0b exp 0", c, q_valid); end
    end
    checks++;
    if (dut.state_q !== IDLE) begin errors++; $display("FAIL mask000_state got %0d exp %0d", dut.state_q, IDLE); end
    do_reset();
    mask = 3'b110;
    en   = 1'b1;
    step();
    checks++;
    if (s !== 2'd1) begin errors++; $display("FAIL mask110_idle_skip got %0h exp 1", s); end
  endtask
`endif

  initial begin
    rst_n   = 1'b0;
    en      = 1'b0;
    q_ready = 1'b0;
    mask    = 3'b111;
    test_reset();
    test_scan();
    test_backpressure();
    test_en_drop();
    test_reset_mid();
`ifdef SEL_SCAN_MASK_EN
    test_mask();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/sel_scan.md
SEL_SCAN -- requirements
Module: sel_scan

Interface
REQ-001 Parameter WIDTH, default 8: data width of the scanned mux output.
REQ-002 Parameter DWELL, default 4: settle cycles per source; legal range 1..255.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on rising clk edge.
REQ-005 en  input  1  scan enable.
REQ-006 mask  input  3  per-source enable, bit i = source i; present only when SEL_SCAN_MASK_EN is defined.
REQ-007 y  input  WIDTH  data returned by the downstream 3:1 mux for the current select.
REQ-008 s  output  2  select driven into the 3:1 mux; 0=d0, 1=d1, 2=d2.
REQ-009 q  output  WIDTH  captured sample.
REQ-010 q_sel  output  2  source index of q.
REQ-011 q_valid  output  1  q/q_sel valid.
REQ-012 q_ready  input  1  consumer accepts q when high with q_valid.

Function
REQ-013 States: IDLE, SETTLE, HOLD; all outputs registered.
REQ-014 IDLE, en=1 -> SETTLE, dwell count = DWELL-1; if the current s is masked, s moves to the next enabled source on the same edge.
REQ-015 SETTLE: s held constant; count decrements each cycle; at count 0, next edge loads q<=y, q_sel<=s, q_valid<=1, state HOLD.
REQ-016 Latency: q_valid rises exactly DWELL cycles after s last changed.
REQ-017 HOLD: q, q_sel, s, q_valid held until q_valid&&q_ready.
REQ-018 On handshake: next edge clears q_valid, advances s to the next enabled source, enters SETTLE (en=1) or IDLE (en=0).
REQ-019 Advance order 0->1->2->0 with wrap; masked sources skipped; if only the current source is enabled, s is unchanged and that source is resampled.
REQ-020 mask==0: stay in / return to IDLE at the next decision point; q_valid never asserts.
REQ-021 en=0 during SETTLE: next edge -> IDLE, sample discarded, s unchanged, no q_valid.
REQ-022 en=0 during HOLD: q_valid stays until handshake, then IDLE.
REQ-023 mask changes during SETTLE/HOLD do not affect the current source; new mask applies at the next advance.
REQ-024 s never takes value 2'b11.
REQ-025 Full throughput with q_ready tied high: one sample per DWELL+1 cycles.

Reset
REQ-026 rst_n=0 at any edge, in any state: state=IDLE, s=0, q=0, q_sel=0, q_valid=0, count=0.
REQ-027 Reset mid-SETTLE/HOLD discards the in-flight sample; no q_valid after reset until a full DWELL elapses.

Configuration
REQ-028 Macro SEL_SCAN_MASK_EN defined: mask port present, skipping per REQ-019/020/023.
REQ-029 Macro SEL_SCAN_MASK_EN undefined: mask port absent, all three sources always enabled, behaviour otherwise identical.

Structure
REQ-030 Package sel_scan_pkg holds: state enum type, 2-bit sel_t typedef, constants SEL_D0=0, SEL_D1=1, SEL_D2=2, and the next-enabled-source function.
REQ-031 Sub-module dwell_cnt (load, decrement, zero flag, width from DWELL) instantiated once.

Verification
REQ-032 rst_n=0 with en=1, q_ready=1 for 3 cycles -> s=0, q=0, q_sel=0, q_valid=0 throughout.
REQ-033 WIDTH=8, DWELL=4, d0/d1/d2=0x11/0x22/0x33, mask=111, q_ready=1, en rises cycle 0 -> q_valid at cycles 4, 9, 14, 19 with q=0x11, 0x22, 0x33, 0x11; q_sel=0, 1, 2, 0.
REQ-034 As REQ-033 but q_ready=0 for 10 cycles after first q_valid -> q=0x11, q_sel=0, s=0, q_valid=1 stable all 10 cycles; resumes on q_ready=1.
REQ-035 mask=101 -> q_sel sequence 0, 2, 0, 2; mask=000 -> no q_valid over 50 cycles, state IDLE.
REQ-036 en=0 at cycle 2 of SETTLE -> no q_valid, s unchanged; rst_n=0 at cycle 2 of SETTLE -> all outputs reset values next edge.
REQ-037 Build without SEL_SCAN_MASK_EN -> REQ-033 sequence exactly reproduced.
